// File: rtl/uart_rx_deframer_pkg.sv
// Shared definitions for the UART receive deframer.
// Provides the frame width, parity codes and FSM state encodings, plus a helper
// that decides whether a latched parity_type reserves a parity slot.
package uart_rx_deframer_pkg;

  localparam int DATA_BITS = 8;

  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // 00 and 11 both mean "no parity slot on the line".
  function automatic logic has_parity(input logic [1:0] ptype);
    return (ptype == PAR_ODD) || (ptype == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_rx_deframer_if.sv
// Bus between a UART line source / frame consumer and uart_rx_deframer.
// Signals:
//   rx_serial   line input (idles high)
//   parity_type 01 odd, 10 even, 00/11 none
//   raw_data    received data, bit0 = first bit on the line
//   parity_bit  sampled parity slot (0 when no parity)
//   start_bit   sampled start slot (0 = valid)
//   stop_bit    sampled stop slot (1 = valid)
//   rx_flag     one-cycle pulse, frame fields valid
//   rx_busy     frame reception in progress
// Modports: master = line driver / consumer, slave = deframer.
interface uart_rx_deframer_if;
  import uart_rx_deframer_pkg::*;

  logic                 rx_serial;
  logic [1:0]           parity_type;
  logic [DATA_BITS-1:0] raw_data;
  logic                 parity_bit;
  logic                 start_bit;
  logic                 stop_bit;
  logic                 rx_flag;
  logic                 rx_busy;

  modport master (
    output rx_serial, parity_type,
    input  raw_data, parity_bit, start_bit, stop_bit, rx_flag, rx_busy
  );

  modport slave (
    input  rx_serial, parity_type,
    output raw_data, parity_bit, start_bit, stop_bit, rx_flag, rx_busy
  );

endinterface

// File: rtl/uart_rx_deframer_sync.sv
// Two-flop synchroniser for the asynchronous UART line.
// Both flops reset to 1 so a reset never looks like a start edge.
// Ports: clk, reset (sync, active-high), d (async input), q (synchronised).
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronises the line, detects the start edge,
// samples start/data/parity/stop at mid-bit and presents each frame with a
// one-cycle rx_flag pulse. 8 data bits LSB first, optional parity, 1 stop bit.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high; aborts any frame in progress
//   rx_if  uart_rx_deframer_if.slave (line, parity_type, frame outputs)
// Parameters:
//   CLKS_PER_BIT  clock cycles per bit, >= 4
// Configuration macro:
//   UART_RX_GLITCH_REJECT_EN  when defined, a start slot sampled high aborts
//                             the frame silently; otherwise the frame runs and
//                             start_bit=1 is reported.
module uart_rx_deframer
  import uart_rx_deframer_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic               clk,
  input  logic               reset,
  uart_rx_deframer_if.slave  rx_if
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic rx_s;
  logic rx_prev_q;

  logic [2:0]           state_q,    state_d;
  logic [CNT_W-1:0]     cnt_q,      cnt_d;
  logic [IDX_W-1:0]     idx_q,      idx_d;
  logic [1:0]           ptype_q,    ptype_d;
  logic [DATA_BITS-1:0] data_sh_q,  data_sh_d;
  logic                 par_sh_q,   par_sh_d;
  logic                 start_sh_q, start_sh_d;
  logic                 busy_q,     busy_d;

  logic [DATA_BITS-1:0] raw_q,      raw_d;
  logic                 par_q,      par_d;
  logic                 start_q,    start_d;
  logic                 stop_q,     stop_d;
  logic                 flag_q,     flag_d;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx_if.rx_serial),
    .q     (rx_s)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    ptype_d    = ptype_q;
    data_sh_d  = data_sh_q;
    par_sh_d   = par_sh_q;
    start_sh_d = start_sh_q;
    busy_d     = busy_q;
    raw_d      = raw_q;
    par_d      = par_q;
    start_d    = start_q;
    stop_d     = stop_q;
    flag_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Edge, not level: a line stuck low after a framing error must be
        // seen high once before another frame can start.
        if (!rx_s && rx_prev_q) begin
          state_d  = ST_START;
          cnt_d    = '0;
          idx_d    = '0;
          ptype_d  = rx_if.parity_type;
          par_sh_d = 1'b0;
          busy_d   = 1'b1;
        end
      end

      ST_START: begin
        if (cnt_q == HALF_END) begin
          cnt_d      = '0;
          start_sh_d = rx_s;
`ifdef UART_RX_GLITCH_REJECT_EN
          if (rx_s) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = ST_DATA;
          end
`else
          state_d = ST_DATA;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d            = '0;
          data_sh_d[idx_q] = rx_s;
          if (idx_q == IDX_LAST) begin
            state_d = has_parity(ptype_q) ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_PARITY: begin
        if (cnt_q == BIT_END) begin
          cnt_d    = '0;
          par_sh_d = rx_s;
          state_d  = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_STOP: begin
        // Leave at mid-stop so a back-to-back start edge is caught in time.
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          raw_d   = data_sh_q;
          par_d   = par_sh_q;
          start_d = start_sh_q;
          stop_d  = rx_s;
          flag_d  = 1'b1;
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_prev_q  <= 1'b1;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      ptype_q    <= '0;
      data_sh_q  <= '0;
      par_sh_q   <= 1'b0;
      start_sh_q <= 1'b0;
      busy_q     <= 1'b0;
      raw_q      <= '0;
      par_q      <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      flag_q     <= 1'b0;
    end else begin
      rx_prev_q  <= rx_s;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      ptype_q    <= ptype_d;
      data_sh_q  <= data_sh_d;
      par_sh_q   <= par_sh_d;
      start_sh_q <= start_sh_d;
      busy_q     <= busy_d;
      raw_q      <= raw_d;
      par_q      <= par_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      flag_q     <= flag_d;
    end
  end

  assign rx_if.raw_data   = raw_q;
  assign rx_if.parity_bit = par_q;
  assign rx_if.start_bit  = start_q;
  assign rx_if.stop_bit   = stop_q;
  assign rx_if.rx_flag    = flag_q;
  assign rx_if.rx_busy    = busy_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Testbench for uart_rx_deframer with CLKS_PER_BIT=8.
// Frames are driven bit by bit; the expected frame fields are queued when a
// frame is sent and compared when rx_flag pulses.
module tb_uart_rx_deframer;
  import uart_rx_deframer_pkg::*;

  localparam int CPB = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  uart_rx_deframer_if bus ();

  uart_rx_deframer #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .rx_if (bus)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       p;
    logic       s;
    logic       st;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   flag_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame monitor: compare every rx_flag pulse against the scoreboard.
  always @(negedge clk) begin
    if (bus.rx_flag === 1'b1) begin
      flag_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_flag", 32'(bus.rx_flag), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("raw_data",   32'(bus.raw_data),   32'(e.d));
        chk("parity_bit", 32'(bus.parity_bit), 32'(e.p));
        chk("start_bit",  32'(bus.start_bit),  32'(e.s));
        chk("stop_bit",   32'(bus.stop_bit),   32'(e.st));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.rx_serial = b;
    tick(CPB);
  endtask

  // Drives a full frame; parity_type is switched to pt_mid after the start
  // bit to show the frame keeps the type latched at the start edge.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] pt,
                            input logic pbit, input logic stopv,
                            input logic [1:0] pt_mid);
    exp_t x;
    logic par_en;
    par_en = (pt == 2'b01) || (pt == 2'b10);
    x.d  = d;
    x.p  = par_en ? pbit : 1'b0;
    x.s  = 1'b0;
    x.st = stopv;
    sb.push_back(x);
    bus.parity_type = pt;
    send_bit(1'b0);
    bus.parity_type = pt_mid;
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (par_en) send_bit(pbit);
    send_bit(stopv);
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 40 * CPB) begin
      tick(1);
      k++;
    end
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   fc0;
    exp_t g;
    reset           = 1'b1;
    bus.rx_serial   = 1'b1;
    bus.parity_type = 2'b00;
    tick(3);
    reset = 1'b0;
    tick(1);

    chk("rst_raw_data",   32'(bus.raw_data),   32'd0);
    chk("rst_parity_bit", 32'(bus.parity_bit), 32'd0);
    chk("rst_start_bit",  32'(bus.start_bit),  32'd0);
    chk("rst_stop_bit",   32'(bus.stop_bit),   32'd0);
    chk("rst_rx_flag",    32'(bus.rx_flag),    32'd0);
    chk("rst_rx_busy",    32'(bus.rx_busy),    32'd0);

    tick(200);
    chk("idle_flags",     32'(flag_cnt),       32'd0);
    chk("idle_raw_data",  32'(bus.raw_data),   32'd0);
    chk("idle_rx_busy",   32'(bus.rx_busy),    32'd0);

    // No parity, 0x55.
    send_frame(8'h55, 2'b00, 1'b0, 1'b1, 2'b00);
    wait_drain("frame_55_seen");
    tick(2 * CPB);

    // Odd parity, 0xA3, parity slot 1; parity_type changed mid-frame.
    send_frame(8'hA3, 2'b01, 1'b1, 1'b1, 2'b11);
    wait_drain("frame_a3_seen");
    tick(2 * CPB);

    // Back-to-back, no idle gap.
    fc0 = flag_cnt;
    send_frame(8'h00, 2'b00, 1'b0, 1'b1, 2'b00);
    send_frame(8'hFF, 2'b00, 1'b0, 1'b1, 2'b00);
    wait_drain("b2b_seen");
    chk("b2b_flag_count", 32'(flag_cnt - fc0), 32'd2);
    tick(2 * CPB);

    // 3-cycle low glitch on an idle line.
    fc0 = flag_cnt;
`ifndef UART_RX_GLITCH_REJECT_EN
    g.d  = 8'hFF;
    g.p  = 1'b0;
    g.s  = 1'b1;
    g.st = 1'b1;
    sb.push_back(g);
`endif
    bus.parity_type = 2'b00;
    bus.rx_serial   = 1'b0;
    tick(3);
    bus.rx_serial = 1'b1;
    tick(12 * CPB);
`ifdef UART_RX_GLITCH_REJECT_EN
    chk("glitch_flags",    32'(flag_cnt - fc0),  32'd0);
    chk("glitch_raw_data", 32'(bus.raw_data),    32'hFF);
    chk("glitch_start",    32'(bus.start_bit),   32'd0);
`else
    chk("glitch_flags",    32'(flag_cnt - fc0),  32'd1);
`endif
    chk("glitch_busy",     32'(bus.rx_busy),     32'd0);

    // Framing error: stop slot low; line then held low (must not retrigger).
    fc0 = flag_cnt;
    send_frame(8'h3C, 2'b00, 1'b0, 1'b0, 2'b00);
    tick(2 * CPB);
    wait_drain("stop0_seen");
    chk("stop0_flag_count", 32'(flag_cnt - fc0), 32'd1);
    chk("stop0_busy",       32'(bus.rx_busy),     32'd0);
    bus.rx_serial = 1'b1;
    tick(2 * CPB);

    // Partial frame, then reset during DATA.
    fc0 = flag_cnt;
    bus.rx_serial = 1'b0;
    tick(CPB);
    bus.rx_serial = 1'b0;
    tick(CPB);
    bus.rx_serial = 1'b1;
    tick(CPB);
    chk("mid_frame_busy", 32'(bus.rx_busy), 32'd1);
    reset = 1'b1;
    tick(2);
    bus.rx_serial = 1'b1;
    reset = 1'b0;
    tick(1);
    chk("abort_raw_data", 32'(bus.raw_data),   32'd0);
    chk("abort_parity",   32'(bus.parity_bit), 32'd0);
    chk("abort_start",    32'(bus.start_bit),  32'd0);
    chk("abort_stop",     32'(bus.stop_bit),   32'd0);
    chk("abort_busy",     32'(bus.rx_busy),    32'd0);
    tick(12 * CPB);
    chk("abort_flags",    32'(flag_cnt - fc0), 32'd0);
    chk("abort_idle_busy", 32'(bus.rx_busy),   32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
